// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: drives register-file read selects, captures read data one cycle later,
// and tracks pending destination writes so RAW/WAW hazards stall until writeback retires them.
module operand_fetch_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int SEL_WIDTH   = 4,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_WIDTH-1:0]   in_sel_ra,
  input  logic [SEL_WIDTH-1:0]   in_sel_rb,
  input  logic [SEL_WIDTH-1:0]   in_sel_rc,
  input  logic [2:0]             in_uses,
  input  logic [SEL_WIDTH-1:0]   in_dest_sel,
  input  logic                   in_dest_en,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic [SEL_WIDTH-1:0]   rf_read_sel_ra,
  output logic [SEL_WIDTH-1:0]   rf_read_sel_rb,
  output logic [SEL_WIDTH-1:0]   rf_read_sel_rc,
  input  logic [DATA_WIDTH-1:0]  rf_read_data_ra,
  input  logic [DATA_WIDTH-1:0]  rf_read_data_rb,
  input  logic [DATA_WIDTH-1:0]  rf_read_data_rc,
  input  logic                   wb_en,
  input  logic [SEL_WIDTH-1:0]   wb_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data_ra,
  output logic [DATA_WIDTH-1:0]  out_data_rb,
  output logic [DATA_WIDTH-1:0]  out_data_rc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [SEL_WIDTH-1:0]   out_dest_sel,
  output logic                   out_dest_en
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [NUM_REGS-1:0]    sb_q, sb_d;
  logic [2:0]             mask_q, mask_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [SEL_WIDTH-1:0]   hold_dest_sel_q, hold_dest_sel_d;
  logic                   hold_dest_en_q, hold_dest_en_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_ra_q, out_data_ra_d;
  logic [DATA_WIDTH-1:0]  out_data_rb_q, out_data_rb_d;
  logic [DATA_WIDTH-1:0]  out_data_rc_q, out_data_rc_d;
  logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [SEL_WIDTH-1:0]   out_dest_sel_q, out_dest_sel_d;
  logic                   out_dest_en_q, out_dest_en_d;

  logic [NUM_REGS-1:0]    clr, set, pend;
  logic [SEL_WIDTH-1:0]   src_sel [3];
  logic                   hazard, can_accept, accept;

  assign src_sel[0] = in_sel_ra;
  assign src_sel[1] = in_sel_rb;
  assign src_sel[2] = in_sel_rc;

  assign rf_read_sel_ra = in_sel_ra;
  assign rf_read_sel_rb = in_sel_rb;
  assign rf_read_sel_rc = in_sel_rc;

  // A retiring write is removed from the pending view before the hazard check; the
  // register file bypass supplies that value, so the consumer need not wait.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    clr    = '0;
    set    = '0;
    hazard = 1'b0;
    mask_d = mask_q;
    if (wb_en && (wb_sel != '0)) clr[wb_sel] = 1'b1;
    pend = sb_q & ~clr;
    for (int i = 0; i < 3; i++) begin
      if (in_uses[i] && (src_sel[i] != '0) && pend[src_sel[i]]) hazard = 1'b1;
    end
    if (in_dest_en && (in_dest_sel != '0) && pend[in_dest_sel]) hazard = 1'b1;
    can_accept = ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready))
                 && !hazard && !flush;
    accept = in_valid && in_ready;
    if (accept) begin
      if (in_dest_en && (in_dest_sel != '0)) set[in_dest_sel] = 1'b1;
      for (int i = 0; i < 3; i++) mask_d[i] = in_uses[i] && (src_sel[i] != '0);
    end
  end

  assign in_ready = rst_n && can_accept;

  always_comb begin
    state_d         = state_q;
    sb_d            = (sb_q & ~clr) | set;
    hold_instr_d    = hold_instr_q;
    hold_dest_sel_d = hold_dest_sel_q;
    hold_dest_en_d  = hold_dest_en_q;
    out_valid_d     = out_valid_q;
    out_data_ra_d   = out_data_ra_q;
    out_data_rb_d   = out_data_rb_q;
    out_data_rc_d   = out_data_rc_q;
    out_instr_d     = out_instr_q;
    out_dest_sel_d  = out_dest_sel_q;
    out_dest_en_d   = out_dest_en_q;

    if (accept) begin
      hold_instr_d    = in_instr;
      hold_dest_sel_d = in_dest_sel;
      hold_dest_en_d  = in_dest_en;
    end

    if (flush) begin
      state_d     = ST_EMPTY;
      out_valid_d = 1'b0;
      sb_d        = '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_FETCH;
        ST_FETCH: begin
          state_d        = ST_FULL;
          out_valid_d    = 1'b1;
          out_data_ra_d  = mask_q[0] ? rf_read_data_ra : '0;
          out_data_rb_d  = mask_q[1] ? rf_read_data_rb : '0;
          out_data_rc_d  = mask_q[2] ? rf_read_data_rc : '0;
          out_instr_d    = hold_instr_q;
          out_dest_sel_d = hold_dest_sel_q;
          out_dest_en_d  = hold_dest_en_q;
        end
        ST_FULL: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = accept ? ST_FETCH : ST_EMPTY;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_EMPTY;
      sb_q            <= '0;
      mask_q          <= '0;
      hold_instr_q    <= '0;
      hold_dest_sel_q <= '0;
      hold_dest_en_q  <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_ra_q   <= '0;
      out_data_rb_q   <= '0;
      out_data_rc_q   <= '0;
      out_instr_q     <= '0;
      out_dest_sel_q  <= '0;
      out_dest_en_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      sb_q            <= sb_d;
      mask_q          <= mask_d;
      hold_instr_q    <= hold_instr_d;
      hold_dest_sel_q <= hold_dest_sel_d;
      hold_dest_en_q  <= hold_dest_en_d;
      out_valid_q     <= out_valid_d;
      out_data_ra_q   <= out_data_ra_d;
      out_data_rb_q   <= out_data_rb_d;
      out_data_rc_q   <= out_data_rc_d;
      out_instr_q     <= out_instr_d;
      out_dest_sel_q  <= out_dest_sel_d;
      out_dest_en_q   <= out_dest_en_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data_ra  = out_data_ra_q;
  assign out_data_rb  = out_data_rb_q;
  assign out_data_rc  = out_data_rc_q;
  assign out_instr    = out_instr_q;
  assign out_dest_sel = out_dest_sel_q;
  assign out_dest_en  = out_dest_en_q;

endmodule
